sr_flag_arbiter: RTL and testbench

//  Round-robin arbiter sharing one bank of SR flip-flop flags between NREQ requesters.

---
 rtl/sr_flag_arbiter.sv | 148 ++++++++++++++
 tb/tb_sr_flag_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter granting one requester at a time write access to a bank of SR flags.
// Each granted command is applied one cycle after its grant, with set/reset/hold/conflict semantics.
module sr_flag_arbiter #(
   parameter int NREQ  = 4,
   parameter int NFLAG = 8,
   parameter int IW    = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      cmd_s,
   input  logic [NREQ-1:0]      cmd_r,
   input  logic [NREQ*IW-1:0]   idx,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      ack,
   output logic [NFLAG-1:0]     flags,
   output logic                 conflict,
   output logic                 busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      APPLY = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic [NFLAG-1:0]  flags_q, flags_d;
   logic              conflict_q, conflict_d;
   logic              busy_q, busy_d;
   logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
   logic              s_l_q, s_l_d;
   logic              r_l_q, r_l_d;
   logic [IW-1:0]     idx_l_q, idx_l_d;

   logic [IW-1:0]     idx_a [NREQ];
   logic [PW-1:0]     win_s;
   logic              found_s;
   logic              grant_s;

   // Unpack per-requester indices and scan for the first asserted req starting at rr_ptr.
   always_comb begin
      win_s   = {PW{1'b0}};
      found_s = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         logic [PW-1:0] j;
         idx_a[i] = idx[i*IW +: IW];
         j = PW'((int'(rr_ptr_q) + i) % NREQ);
         if (!found_s && req[j]) begin
            win_s   = j;
            found_s = 1'b1;
         end else begin
            win_s   = win_s;
         end
      end
   end

   // Next-state, grant/ack pulses, latched command and the SR update of the selected flag.
   always_comb begin
      state_d    = state_q;
      gnt_d      = {NREQ{1'b0}};
      ack_d      = {NREQ{1'b0}};
      flags_d    = flags_q;
      conflict_d = conflict_q;
      rr_ptr_d   = rr_ptr_q;
      s_l_d      = s_l_q;
      r_l_d      = r_l_q;
      idx_l_d    = idx_l_q;
      grant_s    = 1'b0;

      case (state_q)
         IDLE: begin
            if (found_s) grant_s = 1'b1;
            else         state_d = IDLE;
         end
         GRANT: begin
            state_d = APPLY;
            ack_d   = gnt_q;
            // An out-of-range index or s=r=1 leaves the bank untouched but is remembered.
            if (({1'b0, idx_l_q} >= (IW+1)'(NFLAG)) || (s_l_q && r_l_q)) begin
               conflict_d = 1'b1;
            end else if (s_l_q) begin
               flags_d[idx_l_q] = 1'b1;
            end else if (r_l_q) begin
               flags_d[idx_l_q] = 1'b0;
            end else begin
               flags_d = flags_q;
            end
         end
         APPLY: begin
            if (found_s) grant_s = 1'b1;
            else         state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (grant_s) begin
         state_d        = GRANT;
         gnt_d[win_s]   = 1'b1;
         s_l_d          = cmd_s[win_s];
         r_l_d          = cmd_r[win_s];
         idx_l_d        = idx_a[win_s];
         rr_ptr_d       = PW'((int'(win_s) + 1) % NREQ);
      end else begin
         rr_ptr_d       = rr_ptr_q;
      end

      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         gnt_q      <= {NREQ{1'b0}};
         ack_q      <= {NREQ{1'b0}};
         flags_q    <= {NFLAG{1'b0}};
         conflict_q <= 1'b0;
         busy_q     <= 1'b0;
         rr_ptr_q   <= {PW{1'b0}};
         s_l_q      <= 1'b0;
         r_l_q      <= 1'b0;
         idx_l_q    <= {IW{1'b0}};
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         ack_q      <= ack_d;
         flags_q    <= flags_d;
         conflict_q <= conflict_d;
         busy_q     <= busy_d;
         rr_ptr_q   <= rr_ptr_d;
         s_l_q      <= s_l_d;
         r_l_q      <= r_l_d;
         idx_l_q    <= idx_l_d;
      end
   end

   assign gnt      = gnt_q;
   assign ack      = ack_q;
   assign flags    = flags_q;
   assign conflict = conflict_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: directed latency/order cases, then random rounds scored against
// a queue of expected (winner, flags, conflict) results from a service-order model.
module tb_sr_flag_arbiter;

   localparam int NREQ  = 4;
   localparam int NFLAG = 8;
   localparam int IW    = 3;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic [NREQ-1:0]     req = 4'b0000;
   logic [NREQ-1:0]     cmd_s = 4'b0000;
   logic [NREQ-1:0]     cmd_r = 4'b0000;
   logic [NREQ*IW-1:0]  idx = 12'h000;
   logic [NREQ-1:0]     gnt, ack;
   logic [NFLAG-1:0]    flags;
   logic                conflict, busy;

   int checks = 0;
   int passed = 0;
   bit mon_en = 1'b0;

   typedef struct {
      int         w;
      logic [7:0] fl;
      logic       cf;
   } exp_t;
   exp_t sb[$];

   sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .IW(IW)) dut (
      .clk(clk), .rst(rst), .req(req), .cmd_s(cmd_s), .cmd_r(cmd_r), .idx(idx),
      .gnt(gnt), .ack(ack), .flags(flags), .conflict(conflict), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] onehot(int w);
      logic [3:0] v;
      v = 4'b0000;
      v[w] = 1'b1;
      return v;
   endfunction

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic fail_line(string nm);
      checks++;
      $display("FAIL %s: got event expected none", nm);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      req = 4'b0000;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic issue(int i, logic s, logic r, logic [2:0] ix);
      req[i]          = 1'b1;
      cmd_s[i]        = s;
      cmd_r[i]        = r;
      idx[i*IW +: IW] = ix;
   endtask

   // Single command: gnt one cycle after issue, ack plus flag result the cycle after that.
   task automatic run_cmd(string nm, int i, logic s, logic r, logic [2:0] ix,
                          logic [7:0] exp_fl, logic exp_cf);
      issue(i, s, r, ix);
      @(negedge clk);
      check({nm, "_gnt"}, gnt, onehot(i));
      check({nm, "_ack_early"}, ack, 4'b0000);
      req[i] = 1'b0;
      @(negedge clk);
      check({nm, "_ack"}, ack, onehot(i));
      check({nm, "_gnt_low"}, gnt, 4'b0000);
      check({nm, "_flags"}, flags, exp_fl);
      check({nm, "_conflict"}, conflict, exp_cf);
   endtask

   // Scoreboard monitor: every gnt must match the head expectation, every ack pops it.
   always @(negedge clk) begin
      if (mon_en) begin
         if (gnt != 4'b0000) begin
            if (sb.size() == 0) fail_line("sb_gnt_unexpected");
            else check("sb_gnt", gnt, onehot(sb[0].w));
         end
         if (ack != 4'b0000) begin
            if (sb.size() == 0) begin
               fail_line("sb_ack_unexpected");
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("sb_ack", ack, onehot(e.w));
               check("sb_flags", flags, e.fl);
               check("sb_conflict", conflict, e.cf);
            end
         end
      end
   end

   initial begin
      logic [7:0] m_fl;
      logic       m_cf;
      int         m_ptr;

      // Reset state
      @(negedge clk);
      rst = 1'b1;
      check("rst_gnt", gnt, 4'b0000);
      check("rst_ack", ack, 4'b0000);
      check("rst_flags", flags, 8'h00);
      check("rst_conflict", conflict, 1'b0);
      check("rst_busy", busy, 1'b0);

      // Reset aborts a latched command: no ack, bank cleared
      run_cmd("pre_rst", 0, 1'b1, 1'b0, 3'd3, 8'h08, 1'b0);
      @(negedge clk);
      issue(1, 1'b1, 1'b0, 3'd6);
      @(negedge clk);
      check("abort_gnt", gnt, 4'b0010);
      rst = 1'b0;
      req = 4'b0000;
      @(negedge clk);
      rst = 1'b1;
      check("abort_ack", ack, 4'b0000);
      check("abort_flags", flags, 8'h00);
      check("abort_busy", busy, 1'b0);
      check("abort_conflict", conflict, 1'b0);
      @(negedge clk);
      check("abort_ack_later", ack, 4'b0000);
      check("abort_flags_later", flags, 8'h00);

      // Single set then reset of flag 5 by requester 2
      do_reset();
      run_cmd("set5", 2, 1'b1, 1'b0, 3'd5, 8'h20, 1'b0);
      @(negedge clk);
      run_cmd("clr5", 2, 1'b0, 1'b1, 3'd5, 8'h00, 1'b0);

      // Round robin with all requests held: 0,1,2,3,0 every other cycle, busy stays high
      do_reset();
      req = 4'b1111;
      cmd_s = 4'b0000;
      cmd_r = 4'b0000;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("rr_gnt", gnt, (c % 2 == 0) ? onehot((c / 2) % 4) : 4'b0000);
         check("rr_busy", busy, 1'b1);
      end
      req = 4'b0000;
      repeat (3) @(negedge clk);
      check("rr_idle_busy", busy, 1'b0);

      // Pointer wrap after serving requester 3
      do_reset();
      run_cmd("wrap_pre", 3, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
      req = 4'b1001;
      @(negedge clk);
      check("wrap_gnt0", gnt, 4'b0001);
      req = 4'b1000;
      @(negedge clk);
      @(negedge clk);
      check("wrap_gnt3", gnt, 4'b1000);
      req = 4'b0000;
      repeat (3) @(negedge clk);

      // Invalid s=r=1 leaves flags alone; conflict is sticky
      do_reset();
      run_cmd("inv_pre", 1, 1'b1, 1'b0, 3'd1, 8'h02, 1'b0);
      @(negedge clk);
      run_cmd("inv", 1, 1'b1, 1'b1, 3'd1, 8'h02, 1'b1);
      @(negedge clk);
      run_cmd("inv_post", 0, 1'b1, 1'b0, 3'd4, 8'h12, 1'b1);

      // Hold command: ack only
      do_reset();
      run_cmd("hold", 0, 1'b0, 1'b0, 3'd3, 8'h00, 1'b0);

      // Random rounds against the service-order model
      do_reset();
      m_fl   = 8'h00;
      m_cf   = 1'b0;
      m_ptr  = 0;
      mon_en = 1'b1;
      for (int rnd = 0; rnd < 60; rnd++) begin
         logic [3:0] pend;
         logic [3:0] s_v, r_v;
         logic [2:0] ix_v [4];
         int         cyc;
         pend = 4'($urandom_range(1, 15));
         for (int i = 0; i < 4; i++) begin
            s_v[i]  = 1'($urandom_range(0, 1));
            r_v[i]  = ($urandom_range(0, 15) == 0) ? s_v[i] : ~s_v[i];
            if ($urandom_range(0, 5) == 0) r_v[i] = 1'b0;
            if ($urandom_range(0, 5) == 0) s_v[i] = 1'b0;
            ix_v[i] = 3'($urandom_range(0, 7));
         end
         // All pending requesters are posted together, so the service order is fixed now.
         begin
            logic [3:0] left;
            left = pend;
            while (left != 4'b0000) begin
               int w;
               exp_t e;
               w = -1;
               for (int k = 0; k < 4; k++)
                  if (w < 0 && left[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
               if (s_v[w] && r_v[w]) m_cf = 1'b1;
               else if (s_v[w])      m_fl[ix_v[w]] = 1'b1;
               else if (r_v[w])      m_fl[ix_v[w]] = 1'b0;
               e.w  = w;
               e.fl = m_fl;
               e.cf = m_cf;
               sb.push_back(e);
               left[w] = 1'b0;
               m_ptr   = (w + 1) % 4;
            end
         end
         for (int i = 0; i < 4; i++)
            if (pend[i]) issue(i, s_v[i], r_v[i], ix_v[i]);
         cyc = 0;
         while ((req != 4'b0000 || sb.size() != 0) && cyc < 60) begin
            @(negedge clk);
            req = req & ~gnt;
            cyc++;
         end
         if (cyc >= 60) begin
            fail_line("round_timeout");
            sb.delete();
            req = 4'b0000;
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      @(negedge clk);
      @(negedge clk);
      mon_en = 1'b0;
      check("final_flags", flags, m_fl);
      check("final_conflict", conflict, m_cf);
      check("final_busy", busy, 1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
